// File: rtl/counter_cmd_arbiter.sv
// Two-requester round-robin sequencer for a shared 4-bit up/down counter.
// Turns LOAD/UP/DOWN commands into per-cycle counter controls and stops early at the limits.
module counter_cmd_arbiter #(
    parameter int unsigned TOP   = 12,
    parameter int unsigned STEPW = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [1:0] cmd0,
    input  logic [5:0] arg0,
    output logic       ack0,
    output logic       done0,
    input  logic       req1,
    input  logic [1:0] cmd1,
    input  logic [5:0] arg1,
    output logic       ack1,
    output logic       done1,
    input  logic [3:0] cnt_out,
    output logic       cnt_en,
    output logic       cnt_dir,
    output logic       cnt_load,
    output logic [5:0] cnt_data,
    output logic       busy,
    output logic       owner,
    output logic       sat
);
    localparam int unsigned CNTW = 4;
    localparam int unsigned ARGW = 6;
    localparam int unsigned CMDW = 2;
    localparam logic [CNTW-1:0] TOP_V = CNTW'(TOP);
    localparam logic [CMDW-1:0] CMD_LOAD = 2'b01;
    localparam logic [CMDW-1:0] CMD_UP   = 2'b10;
    localparam logic [CMDW-1:0] CMD_DOWN = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [CMDW-1:0]   cmd_q, cmd_d;
    logic [ARGW-1:0]   arg_q, arg_d;
    logic [STEPW-1:0]  rem_q, rem_d;
    logic              ptr_q, ptr_d;
    logic              ack0_q, ack0_d, ack1_q, ack1_d;
    logic              done0_q, done0_d, done1_q, done1_d;
    logic              cnt_en_q, cnt_en_d, cnt_dir_q, cnt_dir_d, cnt_load_q, cnt_load_d;
    logic [ARGW-1:0]   cnt_data_q, cnt_data_d;
    logic              busy_q, busy_d, owner_q, owner_d, sat_q, sat_d;
    logic              gnt_idx, fin, at_limit;
    logic [ARGW-1:0]   arg_sel;

    // Limit test uses the counter value settled from the previous cycle's step.
    assign at_limit = (cmd_q == CMD_UP) ? (cnt_out >= TOP_V) : (cnt_out == '0);

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        arg_d      = arg_q;
        rem_d      = rem_q;
        ptr_d      = ptr_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        cnt_en_d   = 1'b0;
        cnt_dir_d  = 1'b0;
        cnt_load_d = 1'b0;
        cnt_data_d = '0;
        busy_d     = busy_q & ~(done0_q | done1_q);
        owner_d    = owner_q;
        sat_d      = sat_q;
        gnt_idx    = 1'b0;
        arg_sel    = arg0;
        fin        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    gnt_idx = (req0 && req1) ? ptr_q : req1;
                    arg_sel = gnt_idx ? arg1 : arg0;
                    cmd_d   = gnt_idx ? cmd1 : cmd0;
                    arg_d   = arg_sel;
                    rem_d   = arg_sel[STEPW-1:0];
                    ack0_d  = ~gnt_idx;
                    ack1_d  = gnt_idx;
                    owner_d = gnt_idx;
                    sat_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (cmd_q)
                    CMD_LOAD: begin
                        cnt_en_d   = 1'b1;
                        cnt_load_d = 1'b1;
                        cnt_data_d = arg_q;
                        state_d    = S_DONE;
                    end
                    CMD_UP, CMD_DOWN: begin
                        if (rem_q == '0) begin
                            fin     = 1'b1;
                            state_d = S_DONE;
                        end else if (at_limit) begin
                            fin     = 1'b1;
                            sat_d   = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            cnt_en_d  = 1'b1;
                            cnt_dir_d = (cmd_q == CMD_UP);
                            rem_d     = rem_q - STEPW'(1);
                            if (rem_q == STEPW'(1)) begin
                                state_d = S_DONE;
                            end
                        end
                    end
                    default: begin
                        fin     = 1'b1;
                        state_d = S_DONE;
                    end
                endcase
            end
            S_DONE: begin
                // A step still in flight delays the done pulse until it has landed.
                fin     = cnt_en_q;
                ptr_d   = ~owner_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        done0_d = fin & ~owner_q;
        done1_d = fin & owner_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cmd_q      <= '0;
            arg_q      <= '0;
            rem_q      <= '0;
            ptr_q      <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            cnt_en_q   <= 1'b0;
            cnt_dir_q  <= 1'b0;
            cnt_load_q <= 1'b0;
            cnt_data_q <= '0;
            busy_q     <= 1'b0;
            owner_q    <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            arg_q      <= arg_d;
            rem_q      <= rem_d;
            ptr_q      <= ptr_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            cnt_en_q   <= cnt_en_d;
            cnt_dir_q  <= cnt_dir_d;
            cnt_load_q <= cnt_load_d;
            cnt_data_q <= cnt_data_d;
            busy_q     <= busy_d;
            owner_q    <= owner_d;
            sat_q      <= sat_d;
        end
    end

    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign done0    = done0_q;
    assign done1    = done1_q;
    assign cnt_en   = cnt_en_q;
    assign cnt_dir  = cnt_dir_q;
    assign cnt_load = cnt_load_q;
    assign cnt_data = cnt_data_q;
    assign busy     = busy_q;
    assign owner    = owner_q;
    assign sat      = sat_q;

endmodule

// File: tb/tb_counter_cmd_arbiter.sv
// Bench for counter_cmd_arbiter: directed scenarios plus random traffic, checked against
// a transaction-level model of arbitration, step counts, saturation and latency.
`timescale 1ns/1ps
module tb_counter_cmd_arbiter;
    localparam int TOP      = 12;
    localparam int NOP      = 0;
    localparam int LOAD     = 1;
    localparam int UP       = 2;
    localparam int DOWN     = 3;
    localparam int WAIT_MAX = 60;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [1:0] cmd0 = 2'd0, cmd1 = 2'd0;
    logic [5:0] arg0 = 6'd0, arg1 = 6'd0;
    logic       ack0, ack1, done0, done1;
    logic       cnt_en, cnt_dir, cnt_load, busy, owner, sat;
    logic [5:0] cnt_data;
    logic [3:0] cnt_out = 4'd0;

    int n_vec = 0;
    int n_err = 0;
    int pend_cmd [2];
    int pend_arg [2];

    counter_cmd_arbiter #(.TOP(12), .STEPW(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .cmd0(cmd0), .arg0(arg0), .ack0(ack0), .done0(done0),
        .req1(req1), .cmd1(cmd1), .arg1(arg1), .ack1(ack1), .done1(done1),
        .cnt_out(cnt_out), .cnt_en(cnt_en), .cnt_dir(cnt_dir), .cnt_load(cnt_load),
        .cnt_data(cnt_data), .busy(busy), .owner(owner), .sat(sat)
    );

    always #5 clk = ~clk;

    // Shared counter: samples control on the falling edge, saturates at 0 and 15.
    always @(negedge clk) begin
        if (cnt_en) begin
            if (cnt_load)      cnt_out <= cnt_data[3:0];
            else if (cnt_dir)  cnt_out <= (cnt_out == 4'd15) ? cnt_out : cnt_out + 4'd1;
            else               cnt_out <= (cnt_out == 4'd0) ? cnt_out : cnt_out - 4'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
        end
    endtask

    // ---------------- reference model / monitor ----------------
    bit fav = 1'b0, exp_owner = 1'b0, exp_sat = 1'b0, act = 1'b0, act_idx = 1'b0, act_sat = 1'b0;
    int act_cmd, act_arg, act_start, exp_steps, exp_cnt, exp_lat, lat, en_seen, room, n_req;

    always @(posedge clk) begin
        #1;
        if (rst) begin
            chk("rst_busy",  32'(busy), 0);
            chk("rst_ack",   32'(ack0 | ack1), 0);
            chk("rst_done",  32'(done0 | done1), 0);
            chk("rst_en",    32'(cnt_en), 0);
            chk("rst_load",  32'(cnt_load), 0);
            chk("rst_sat",   32'(sat), 0);
            chk("rst_owner", 32'(owner), 0);
            act = 1'b0; fav = 1'b0; exp_owner = 1'b0; exp_sat = 1'b0;
        end else begin
            chk("single_ack", 32'(ack0 & ack1), 0);
            if (ack0 | ack1) begin
                act_idx = ack1;
                chk("ack_when_idle", 32'(act), 0);
                chk("grant_pick", 32'(act_idx), 32'((req0 && req1) ? fav : req1));
                chk("grant_had_req", 32'(act_idx ? req1 : req0), 1);
                act_cmd   = pend_cmd[act_idx];
                act_arg   = pend_arg[act_idx];
                act_start = int'(cnt_out);
                n_req     = act_arg % 16;
                case (act_cmd)
                    LOAD: begin
                        exp_steps = 1; exp_cnt = act_arg % 16; act_sat = 1'b0; exp_lat = 2;
                    end
                    UP, DOWN: begin
                        if (act_cmd == UP) room = (act_start >= TOP) ? 0 : TOP - act_start;
                        else               room = act_start;
                        if (n_req <= room) begin
                            exp_steps = n_req; act_sat = 1'b0; exp_lat = n_req + 1;
                        end else begin
                            exp_steps = room; act_sat = 1'b1; exp_lat = room + 1;
                        end
                        exp_cnt = (act_cmd == UP) ? act_start + exp_steps : act_start - exp_steps;
                    end
                    default: begin
                        exp_steps = 0; exp_cnt = act_start; act_sat = 1'b0; exp_lat = 1;
                    end
                endcase
                act = 1'b1; lat = 0; en_seen = 0; exp_owner = act_idx; exp_sat = 1'b0;
            end else if (act) begin
                lat++;
            end

            chk("owner", 32'(owner), 32'(exp_owner));
            chk("busy", 32'(busy), 32'(act));
            if (act) begin
                if (cnt_en) begin
                    en_seen++;
                    chk("load_strobe", 32'(cnt_load), 32'(act_cmd == LOAD));
                    if (act_cmd == LOAD) chk("load_data", 32'(cnt_data), 32'(act_arg));
                    else                 chk("step_dir", 32'(cnt_dir), 32'(act_cmd == UP));
                end else begin
                    chk("load_without_en", 32'(cnt_load), 0);
                end
                if (act_cmd == UP && act_start <= TOP)
                    chk("up_ceiling", 32'(int'(cnt_out) <= TOP), 1);
            end else begin
                chk("idle_en", 32'(cnt_en), 0);
                chk("idle_load", 32'(cnt_load), 0);
            end

            if (done0 | done1) begin
                chk("done_expected", 32'(act), 1);
                chk("single_done", 32'(done0 & done1), 0);
                chk("done_owner", 32'(done1), 32'(act_idx));
                chk("latency", 32'(lat), 32'(exp_lat));
                chk("step_count", 32'(en_seen), 32'(exp_steps));
                chk("final_cnt", 32'(cnt_out), 32'(exp_cnt));
                exp_sat = act_sat;
                chk("sat_at_done", 32'(sat), 32'(exp_sat));
                fav = ~act_idx;
                act = 1'b0;
            end else begin
                chk("sat_hold", 32'(sat), 32'(exp_sat));
                if (act && lat > WAIT_MAX) begin
                    chk("done_in_time", 32'(lat), 32'(exp_lat));
                    act = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int idx, input bit r, input int c, input int a);
        pend_cmd[idx] = c;
        pend_arg[idx] = a;
        if (idx == 0) begin req0 = r; cmd0 = 2'(c); arg0 = 6'(a); end
        else          begin req1 = r; cmd1 = 2'(c); arg1 = 6'(a); end
    endtask

    task automatic wait_ack(input int idx);
        int k = 0;
        do begin @(posedge clk); #2; k++; end
        while (!(idx == 1 ? ack1 : ack0) && k < WAIT_MAX);
        chk("ack_in_time", 32'(k < WAIT_MAX), 1);
    endtask

    task automatic wait_done(input int idx);
        int k = 0;
        do begin @(posedge clk); #2; k++; end
        while (!(idx == 1 ? done1 : done0) && k < WAIT_MAX);
        chk("done_seen_in_time", 32'(k < WAIT_MAX), 1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < WAIT_MAX) begin @(posedge clk); #2; k++; end
        chk("idle_in_time", 32'(busy), 0);
    endtask

    task automatic send(input int idx, input int c, input int a);
        drive(idx, 1'b1, c, a);
        wait_ack(idx);
        drive(idx, 1'b0, c, a);
        wait_done(idx);
    endtask

    task automatic rand_req(input int idx, input bit acked);
        bit cur = (idx == 1) ? req1 : req0;
        if (cur && acked) begin
            if ($urandom_range(1, 0) == 1) drive(idx, 1'b1, $urandom_range(3, 0), $urandom_range(63, 0));
            else                           drive(idx, 1'b0, pend_cmd[idx], pend_arg[idx]);
        end else if (!cur && $urandom_range(3, 0) == 0) begin
            drive(idx, 1'b1, $urandom_range(3, 0), $urandom_range(63, 0));
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int na0, na1, k, steps;
        int order [$];
        pend_cmd[0] = 0; pend_cmd[1] = 0; pend_arg[0] = 0; pend_arg[1] = 0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        send(0, LOAD, 3);
        chk("tp_load_cnt", 32'(cnt_out), 3);
        chk("tp_load_sat", 32'(sat), 0);
        send(1, UP, 5);
        chk("tp_up5_cnt", 32'(cnt_out), 8);
        chk("tp_up5_sat", 32'(sat), 0);
        send(0, UP, 10);
        chk("tp_up10_cnt", 32'(cnt_out), 12);
        chk("tp_up10_sat", 32'(sat), 1);
        send(1, DOWN, 0);

        // Both held with requester 0 favoured: grants must alternate 0,1,0,1.
        drive(0, 1'b1, LOAD, 7);
        drive(1, 1'b1, UP, 2);
        na0 = 0; na1 = 0; k = 0;
        while ((na0 < 2 || na1 < 2) && k < 200) begin
            @(posedge clk); #2; k++;
            if (ack0) begin order.push_back(0); na0++; if (na0 == 2) drive(0, 1'b0, LOAD, 7); end
            if (ack1) begin order.push_back(1); na1++; if (na1 == 2) drive(1, 1'b0, UP, 2); end
        end
        chk("rr_ack_count", 32'(order.size()), 4);
        foreach (order[i]) chk("rr_order", 32'(order[i]), 32'(i % 2));
        wait_idle();

        send(0, DOWN, 0);
        send(1, NOP, 0);
        send(0, LOAD, 4);
        send(1, DOWN, 9);
        chk("tp_down9_cnt", 32'(cnt_out), 0);
        chk("tp_down9_sat", 32'(sat), 1);

        // Reset in the middle of an UP 8 after three steps.
        drive(1, 1'b1, UP, 8);
        wait_ack(1);
        drive(1, 1'b0, UP, 8);
        k = 0; steps = 0;
        while (steps < 3 && k < WAIT_MAX) begin @(posedge clk); #2; k++; if (cnt_en) steps++; end
        chk("pre_rst_steps", 32'(steps), 3);
        rst = 1'b1;
        @(posedge clk); #2;
        chk("rst_abort_en", 32'(cnt_en), 0);
        chk("rst_abort_busy", 32'(busy), 0);
        chk("rst_abort_done", 32'(done1), 0);
        rst = 1'b0;
        drive(0, 1'b1, NOP, 0);
        drive(1, 1'b1, NOP, 0);
        k = 0;
        do begin @(posedge clk); #2; k++; end while (!(ack0 | ack1) && k < WAIT_MAX);
        chk("post_rst_grant_is_0", 32'(ack0 & ~ack1), 1);
        drive(0, 1'b0, NOP, 0);
        wait_ack(1);
        drive(1, 1'b0, NOP, 0);
        wait_idle();

        // Random traffic from both requesters.
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(posedge clk); #2;
            rand_req(0, ack0);
            rand_req(1, ack1);
        end
        k = 0;
        while ((req0 || req1 || busy) && k < 400) begin
            @(posedge clk); #2; k++;
            if (req0 && ack0) drive(0, 1'b0, pend_cmd[0], pend_arg[0]);
            if (req1 && ack1) drive(1, 1'b0, pend_cmd[1], pend_arg[1]);
        end
        chk("drain", 32'(req0 | req1 | busy), 0);
        repeat (3) @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
